// File: rtl/isb_training_unit.sv
// ISB training front end: per-PC last-address table feeding a pair FIFO.
// Each PC-local address transition becomes one (prev, curr) pair for the ISB mapper.
module isb_training_unit #(
  parameter int ADDR_W     = 16,
  parameter int PC_W       = 16,
  parameter int TU_DEPTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_in,
  input  logic [PC_W-1:0]   pc,
  input  logic [ADDR_W-1:0] addr,
  output logic              in_ready,
  input  logic              flush,
  output logic              pair_valid,
  output logic [ADDR_W-1:0] pair_prev,
  output logic [ADDR_W-1:0] pair_curr,
  input  logic              pair_ready,
  output logic [15:0]       drop_count
);

  localparam int IDX_W = $clog2(TU_DEPTH);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int FA_W  = $clog2(FIFO_DEPTH);

  // Training table
  logic [TU_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [TU_DEPTH];
  logic [ADDR_W-1:0]   last_q [TU_DEPTH];

  // Pair FIFO; pointers carry one extra bit so full and empty are distinguishable
  logic [ADDR_W-1:0] prev_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] curr_mem_q [FIFO_DEPTH];
  logic [FA_W:0]     wr_ptr_q, wr_ptr_d;
  logic [FA_W:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       drop_q, drop_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic [ADDR_W-1:0] last_rd;
  logic              hit, same_addr;
  logic              fifo_full, fifo_empty;
  logic              accept, reject, push, pop, tbl_wr;

  assign idx     = pc[IDX_W-1:0];
  assign tag_in  = pc[PC_W-1:IDX_W];
  assign last_rd = last_q[idx];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FA_W] != rd_ptr_q[FA_W]) &&
                      (wr_ptr_q[FA_W-1:0] == rd_ptr_q[FA_W-1:0]);

  always_comb begin
    hit       = valid_q[idx] && (tag_q[idx] == tag_in);
    same_addr = (addr == last_rd);
    accept    = v_in && !fifo_full && !flush;
    reject    = v_in && fifo_full && !flush;
    push      = accept && hit && !same_addr;
    // A miss claims the entry; a hit with a new address advances last_addr
    tbl_wr    = accept && !(hit && same_addr);
    pop       = !fifo_empty && pair_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + (FA_W+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (FA_W+1)'(1);
    if (reject && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < TU_DEPTH; i++) begin
        tag_q[i]  <= '0;
        last_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (tbl_wr) begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= tag_in;
      last_q[idx]  <= addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        prev_mem_q[i] <= '0;
        curr_mem_q[i] <= '0;
      end
    end else if (push) begin
      prev_mem_q[wr_ptr_q[FA_W-1:0]] <= last_rd;
      curr_mem_q[wr_ptr_q[FA_W-1:0]] <= addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign pair_valid = !fifo_empty;
  assign pair_prev  = prev_mem_q[rd_ptr_q[FA_W-1:0]];
  assign pair_curr  = curr_mem_q[rd_ptr_q[FA_W-1:0]];
  assign drop_count = drop_q;

endmodule

// File: tb/tb_isb_training_unit.sv
// Bench for isb_training_unit: directed scenarios plus random traffic against a queue-based model.
module tb_isb_training_unit;
  localparam int AW = 16, PW = 16, TD = 8, FD = 4;

  logic          clk = 0, rst_n = 0;
  logic          v_in = 0, flush = 0, pair_ready = 0;
  logic [PW-1:0] pc = '0;
  logic [AW-1:0] addr = '0;
  logic          in_ready, pair_valid;
  logic [AW-1:0] pair_prev, pair_curr;
  logic [15:0]   drop_count;

  isb_training_unit #(.ADDR_W(AW), .PC_W(PW), .TU_DEPTH(TD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .pc(pc), .addr(addr), .in_ready(in_ready),
    .flush(flush), .pair_valid(pair_valid), .pair_prev(pair_prev), .pair_curr(pair_curr),
    .pair_ready(pair_ready), .drop_count(drop_count));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table owner PC + last address per index, FIFO as a queue of pairs
  bit          m_valid [TD];
  logic [PW-1:0] m_pc  [TD];
  logic [AW-1:0] m_last[TD];
  logic [31:0] mq[$];
  int          m_drop;

  always @(posedge clk or negedge rst_n) begin
    int n, i;
    bit do_pop;
    if (!rst_n) begin
      for (int k = 0; k < TD; k++) m_valid[k] = 0;
      mq.delete();
      m_drop = 0;
    end else begin
      n = mq.size();
      do_pop = (n > 0) && pair_ready;
      i = int'(pc) % TD;
      if (flush) begin
        for (int k = 0; k < TD; k++) m_valid[k] = 0;
      end else if (v_in) begin
        if (n == FD) begin
          if (m_drop < 65535) m_drop++;
        end else if (m_valid[i] && m_pc[i] == pc) begin
          if (m_last[i] != addr) begin
            mq.push_back({m_last[i], addr});
            m_last[i] = addr;
          end
        end else begin
          m_valid[i] = 1; m_pc[i] = pc; m_last[i] = addr;
        end
      end
      if (do_pop) void'(mq.pop_front());
    end
  end

  // Compare process: every negedge, DUT outputs vs model; also logs consumed pairs
  logic [31:0] dut_log[$];
  always @(negedge clk) begin
    chk("in_ready", in_ready, mq.size() < FD);
    chk("pair_valid", pair_valid, mq.size() > 0);
    if (mq.size() > 0) chk("pair_head", {pair_prev, pair_curr}, mq[0]);
    chk("drop_count", drop_count, m_drop);
    if (pair_valid && pair_ready) dut_log.push_back({pair_prev, pair_curr});
  end

  task automatic step(input bit v, input logic [PW-1:0] p, input logic [AW-1:0] a,
                      input bit f, input bit r);
    @(posedge clk); #1;
    v_in = v; pc = p; addr = a; flush = f; pair_ready = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, r);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 0; v_in = 0; flush = 0; pair_ready = 0;
    #10 rst_n = 1;
    dut_log.delete();
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_pair_prev", pair_prev, 0);
    chk("rst_pair_curr", pair_curr, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_in_ready", in_ready, 1);
    #20 rst_n = 1;

    // Single stream
    dut_log.delete();
    for (int k = 0; k < 5; k++) step(1, 16'h0000, AW'(16'h10 + k), 0, 1);
    idle(3, 1);
    chk("single_cnt", dut_log.size(), 4);
    for (int k = 0; k < 4 && k < dut_log.size(); k++)
      chk("single_pair", dut_log[k], {AW'(16'h10 + k), AW'(16'h11 + k)});
    chk("single_drop", drop_count, 0);

    // Backpressure
    do_reset();
    for (int k = 0; k < 7; k++) step(1, 16'h0000, AW'(16'h20 + k), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_drop", drop_count, 2);
    idle(6, 1);
    chk("bp_cnt", dut_log.size(), 4);
    for (int k = 0; k < 4 && k < dut_log.size(); k++)
      chk("bp_pair", dut_log[k], {AW'(16'h20 + k), AW'(16'h21 + k)});

    // Conflict and repeat
    do_reset();
    step(1, 16'h0001, 16'h30, 0, 1);
    step(1, 16'h0009, 16'h40, 0, 1);
    step(1, 16'h0001, 16'h31, 0, 1);
    step(1, 16'h0001, 16'h31, 0, 1);
    idle(3, 1);
    chk("conflict_cnt", dut_log.size(), 0);

    // Interleaved PCs
    do_reset();
    step(1, 16'h2, 16'h50, 0, 1);
    step(1, 16'h3, 16'h60, 0, 1);
    step(1, 16'h2, 16'h51, 0, 1);
    step(1, 16'h3, 16'h61, 0, 1);
    idle(3, 1);
    chk("inter_cnt", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      chk("inter_p0", dut_log[0], {16'h50, 16'h51});
      chk("inter_p1", dut_log[1], {16'h60, 16'h61});
    end

    // Flush
    do_reset();
    step(1, 16'h0, 16'h10, 0, 1);
    step(1, 16'h0, 16'h11, 1, 1);
    step(1, 16'h0, 16'h12, 0, 1);
    idle(3, 1);
    chk("flush_cnt", dut_log.size(), 0);
    chk("flush_drop", drop_count, 0);

    // Reset mid-operation with 3 pairs queued
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 16'h0, AW'(k + 1), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_pairs_pending", pair_valid, 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", pair_valid, 0);
    chk("mid_rst_drop", drop_count, 0);
    #1 rst_n = 1;
    dut_log.delete();
    step(1, 16'h0, 16'h99, 0, 1);
    idle(3, 1);
    chk("mid_rst_miss", dut_log.size(), 0);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [PW-1:0] rp;
      rp = PW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rp = rp | 16'h0100;
      step($urandom_range(0, 3) != 0, rp, AW'($urandom_range(0, 7)),
           $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);
    end
    idle(8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
